bram_pim_arbiter: RTL and testbench
===================================

Name: bram_pim_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one bram_pim instance (96-bit write data, 9-bit address, write enable, 8-bit PIM result) between NUM_REQ requesters.
- Accepts at most one access per cycle and drives registered bram_pim port signals.
- Tracks in-flight reads with a tag pipeline and returns each 8-bit result only to the requester that issued the read.
- Supports a lock input so one requester can hold the port for an uninterrupted back-to-back sequence.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- RD_LAT, 1, cycles from bram_pim address capture to valid bram_pim out; legal range 1..4.

Ports:
- clk  in  1  single clock; also drives the bram_pim clk.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester access request.
- req_lock  in  NUM_REQ  keep the grant on the next cycle while req stays high.
- req_we  in  NUM_REQ  1 = write, 0 = read/compute.
- req_addr  in  NUM_REQ*9  flattened addresses; requester i uses bits [9i+8:9i].
- req_data  in  NUM_REQ*96  flattened write data; requester i uses bits [96i+95:96i].
- grant  out  NUM_REQ  one-hot, combinational; request accepted at the next rising edge.
- rsp_valid  out  NUM_REQ  one-hot, registered; read result valid.
- rsp_data  out  8  registered read result.
- pim_we  out  1  to bram_pim we.
- pim_addr  out  9  to bram_pim addr.
- pim_data  out  96  to bram_pim data.
- pim_out  in  8  from bram_pim out.
- busy  out  1  high while any read is in flight.

Behaviour:
- Reset (reset=0, asynchronous):
  - rr_ptr=0, lock_owner=none.
  - pim_we=0, pim_addr=0, pim_data=0.
  - rsp_valid=0, rsp_data=0, busy=0, tag pipeline cleared.
  - Reads in flight are dropped; no rsp_valid is produced for them after reset.
- Arbitration (combinational):
  - If lock_owner=k and req[k]=1, then grant=1<<k.
  - Otherwise grant goes to the first i with req[i]=1, searching from rr_ptr upward with wrap-around.
  - grant=0 when req=0. grant never has more than one bit set.
- Acceptance edge: any edge with grant[i]=1.
  - pim_we<=req_we[i], pim_addr<=req_addr slice i, pim_data<=req_data slice i.
  - rr_ptr<=(i+1) mod NUM_REQ.
  - lock_owner<=i if req_lock[i]=1, else none.
- Idle edge (no grant): pim_we<=0; pim_addr and pim_data hold their values; lock_owner<=none.
- Lock release: dropping req[k] releases the lock immediately. Round-robin resumes from (k+1).
- Read tag pipeline:
  - Depth RD_LAT+1 stages of {valid, index}.
  - A read accepted at edge E0 produces rsp_valid[i]=1 and rsp_data=pim_out sampled at edge E0+RD_LAT+1.
  - Both are held for exactly one cycle.
- Writes produce no response. A write accepted immediately after a read to the same address does not corrupt that read's returned data; ordering is preserved by the port.
- Back-to-back reads from any mix of requesters give one response per cycle, in acceptance order. Throughput is 1 access/cycle.
- busy=1 while any pipeline stage holds a valid read tag.
- Simultaneous events: a response for requester j and a new grant to j in the same cycle are independent. Both occur.

Test Plan:
- Reset, then req=0001, req_we[0]=0, addr0=0x0A5 -> grant=0001; pim_addr=0x0A5 and pim_we=0 at the next edge; rsp_valid=0001 with rsp_data equal to the model value exactly 2 cycles after acceptance (RD_LAT=1).
- req=1111 held for 8 cycles, no lock -> grant sequence 0001,0010,0100,1000,0001,... with no repeats until all four are served.
- Requester 2 with req_lock=1 for 3 cycles while req=1111 -> grant=0100 for 3 consecutive cycles; after lock drop, next grant=1000.
- Requester 1 writes 96'h..._5A to addr 0x010, then requester 3 reads addr 0x010 on the next cycle -> pim_we sequence 1,0; rsp_valid=1000 with rsp_data from the bram_pim model for the written row.
- Read accepted, reset asserted one cycle later -> all outputs go to zero immediately; no rsp_valid after reset is released; busy=0.
- RD_LAT=3 build with reads from 4 requesters on consecutive cycles -> four rsp_valid pulses on consecutive cycles, each 4 cycles after its acceptance, routed to the correct index.

Source files
------------

// File: rtl/bram_pim_arbiter.sv
// Round-robin arbiter sharing one bram_pim port between NUM_REQ requesters,
// with lock support and a tag pipeline that routes each read result back to its issuer.
module bram_pim_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int RD_LAT  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_lock,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*9-1:0]  req_addr,
  input  logic [NUM_REQ*96-1:0] req_data,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [7:0]            rsp_data,
  output logic                  pim_we,
  output logic [8:0]            pim_addr,
  output logic [95:0]           pim_data,
  input  logic [7:0]            pim_out,
  output logic                  busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] lock_idx;
  logic             lock_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_any;
  logic [IDX_W-1:0] next_ptr;
  logic             sel_we;
  logic             sel_lock;
  logic [8:0]       sel_addr;
  logic [95:0]      sel_data;
  int               cand;

  logic [RD_LAT:0]  tag_valid;
  logic [IDX_W-1:0] tag_idx [RD_LAT+1];
  logic [NUM_REQ-1:0] rsp_next;

  // A live lock wins outright; otherwise search upward from rr_ptr with wrap.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    if (lock_valid && req[lock_idx]) begin
      grant_any = 1'b1;
      grant_idx = lock_idx;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = (int'(rr_ptr) + k) % NUM_REQ;
        if (!grant_any && req[cand[IDX_W-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = cand[IDX_W-1:0];
        end
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_we   = 1'b0;
    sel_lock = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_we   = req_we[i];
        sel_lock = req_lock[i];
        sel_addr = req_addr[i*9 +: 9];
        sel_data = req_data[i*96 +: 96];
      end
    end
    next_ptr = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr     <= '0;
      lock_valid <= 1'b0;
      lock_idx   <= '0;
      pim_we     <= 1'b0;
      pim_addr   <= '0;
      pim_data   <= '0;
    end else if (grant_any) begin
      pim_we     <= sel_we;
      pim_addr   <= sel_addr;
      pim_data   <= sel_data;
      rr_ptr     <= next_ptr;
      lock_valid <= sel_lock;
      lock_idx   <= grant_idx;
    end else begin
      pim_we     <= 1'b0;
      lock_valid <= 1'b0;
    end
  end

  // The oldest tag lines up with pim_out for the read it belongs to.
  always_comb begin
    rsp_next = '0;
    if (tag_valid[RD_LAT]) rsp_next[tag_idx[RD_LAT]] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_valid <= '0;
      for (int k = 0; k <= RD_LAT; k++) tag_idx[k] <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      tag_valid[0] <= grant_any & ~sel_we;
      tag_idx[0]   <= grant_idx;
      for (int k = 1; k <= RD_LAT; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_idx[k]   <= tag_idx[k-1];
      end
      rsp_valid <= rsp_next;
      if (tag_valid[RD_LAT]) rsp_data <= pim_out;
    end
  end

  assign busy = |tag_valid;

endmodule

// File: tb/tb_bram_pim_arbiter.sv
// Scoreboard bench: two arbiters (RD_LAT=1 and RD_LAT=3) share the same stimulus,
// each backed by its own behavioural bram_pim model.
module tb_bram_pim_arbiter;

  logic         clk;
  logic         reset;
  logic [3:0]   req, req_lock, req_we;
  logic [8:0]   a [4];
  logic [95:0]  d [4];
  logic [35:0]  req_addr;
  logic [383:0] req_data;

  logic [3:0]   grant1, grant3, rsp_valid1, rsp_valid3;
  logic [7:0]   rsp_data1, rsp_data3, pim_out1, pim_out3;
  logic         pim_we1, pim_we3, busy1, busy3;
  logic [8:0]   pim_addr1, pim_addr3;
  logic [95:0]  pim_data1, pim_data3;

  logic [95:0]  mem1 [512];
  logic [95:0]  mem3 [512];
  logic [95:0]  shadow [512];
  logic [7:0]   o3 [3];

  typedef struct {
    logic [3:0] vec;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t m1, m3;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  assign req_addr = {a[3], a[2], a[1], a[0]};
  assign req_data = {d[3], d[2], d[1], d[0]};

  bram_pim_arbiter #(.NUM_REQ(4), .RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req), .req_lock(req_lock), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data), .grant(grant1), .rsp_valid(rsp_valid1),
    .rsp_data(rsp_data1), .pim_we(pim_we1), .pim_addr(pim_addr1), .pim_data(pim_data1),
    .pim_out(pim_out1), .busy(busy1)
  );

  bram_pim_arbiter #(.NUM_REQ(4), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .req(req), .req_lock(req_lock), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data), .grant(grant3), .rsp_valid(rsp_valid3),
    .rsp_data(rsp_data3), .pim_we(pim_we3), .pim_addr(pim_addr3), .pim_data(pim_data3),
    .pim_out(pim_out3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [95:0] init_row(input int i);
    return {32'(i * i * 37 + 11), 32'(i * 7 + 3), 32'(i) ^ 32'h5A5A_C3C3};
  endfunction

  function automatic logic [7:0] pim_fn(input logic [95:0] row);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 12; i++) acc = 8'((acc * 3) + row[i*8 +: 8]);
    return acc;
  endfunction

  // Behavioural bram_pim: address captured each edge, result ready RD_LAT edges later.
  always @(posedge clk) begin
    pim_out1 <= pim_fn(mem1[pim_addr1]);
    if (pim_we1) mem1[pim_addr1] <= pim_data1;
  end

  always @(posedge clk) begin
    o3[0] <= pim_fn(mem3[pim_addr3]);
    o3[1] <= o3[0];
    o3[2] <= o3[1];
    if (pim_we3) mem3[pim_addr3] <= pim_data3;
  end
  assign pim_out3 = o3[2];

  task automatic check_output(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One request cycle: check the combinational grant, record expectations, then check the port.
  task automatic apply_stimulus(input logic [3:0] r, input logic [3:0] lk, input logic [3:0] we,
                                input logic [3:0] exp_grant, input string name);
    int idx;
    idx = -1;
    req = r;
    req_lock = lk;
    req_we = we;
    #1;
    check_output({name, " grant lat1"}, 96'(grant1), 96'(exp_grant));
    check_output({name, " grant lat3"}, 96'(grant3), 96'(exp_grant));
    for (int i = 0; i < 4; i++) if (exp_grant[i]) idx = i;
    if (idx >= 0) begin
      if (we[idx]) shadow[a[idx]] = d[idx];
      else begin
        q1.push_back('{exp_grant, pim_fn(shadow[a[idx]]), cyc + 3});
        q3.push_back('{exp_grant, pim_fn(shadow[a[idx]]), cyc + 5});
      end
    end
    @(posedge clk);
    #1;
    if (idx >= 0) begin
      check_output({name, " pim_we"}, 96'(pim_we1), 96'(we[idx]));
      check_output({name, " pim_addr"}, 96'(pim_addr1), 96'(a[idx]));
      if (we[idx]) check_output({name, " pim_data"}, pim_data1, d[idx]);
    end else begin
      check_output({name, " idle pim_we"}, 96'(pim_we1), 96'd0);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid1 != 4'b0000) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL lat1 unexpected rsp: got valid %b expected none", rsp_valid1);
      end else begin
        m1 = q1.pop_front();
        check_output("lat1 rsp_valid", 96'(rsp_valid1), 96'(m1.vec));
        check_output("lat1 rsp_data", 96'(rsp_data1), 96'(m1.data));
        check_output("lat1 rsp cycle", 96'(cyc), 96'(m1.due));
      end
    end else if (q1.size() != 0 && q1[0].due <= cyc) begin
      checks++;
      errors++;
      $display("[TB] FAIL lat1 missing rsp: got none expected valid %b at cycle %0d", q1[0].vec, q1[0].due);
      void'(q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rsp_valid3 != 4'b0000) begin
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL lat3 unexpected rsp: got valid %b expected none", rsp_valid3);
      end else begin
        m3 = q3.pop_front();
        check_output("lat3 rsp_valid", 96'(rsp_valid3), 96'(m3.vec));
        check_output("lat3 rsp_data", 96'(rsp_data3), 96'(m3.data));
        check_output("lat3 rsp cycle", 96'(cyc), 96'(m3.due));
      end
    end else if (q3.size() != 0 && q3[0].due <= cyc) begin
      checks++;
      errors++;
      $display("[TB] FAIL lat3 missing rsp: got none expected valid %b at cycle %0d", q3[0].vec, q3[0].due);
      void'(q3.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish expected finish within 200000 time units");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem1[i] = init_row(i);
      mem3[i] = init_row(i);
      shadow[i] = init_row(i);
    end
    for (int i = 0; i < 4; i++) begin
      a[i] = 9'(32'h020 + i);
      d[i] = '0;
    end
    pim_out1 = 8'h00;
    o3[0] = 8'h00; o3[1] = 8'h00; o3[2] = 8'h00;
    reset = 1'b0;
    req = 4'b0000; req_lock = 4'b0000; req_we = 4'b0000;

    repeat (2) @(posedge clk);
    #1;
    check_output("reset pim_we", 96'(pim_we1), 96'd0);
    check_output("reset pim_addr", 96'(pim_addr1), 96'd0);
    check_output("reset pim_data", pim_data1, 96'd0);
    check_output("reset rsp_valid", 96'(rsp_valid1), 96'd0);
    check_output("reset rsp_data", 96'(rsp_data1), 96'd0);
    check_output("reset busy", 96'(busy1), 96'd0);
    check_output("reset grant", 96'(grant1), 96'd0);
    reset = 1'b1;

    // Single read from requester 0.
    a[0] = 9'h0A5;
    apply_stimulus(4'b0001, 4'b0000, 4'b0000, 4'b0001, "t1 read0");
    check_output("t1 busy lat1", 96'(busy1), 96'd1);
    check_output("t1 busy lat3", 96'(busy3), 96'd1);
    apply_stimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, "t1 idle");

    // Full contention, rotation starts after requester 0.
    apply_stimulus(4'b1111, 4'b0000, 4'b0000, 4'b0010, "t2 rr1");
    apply_stimulus(4'b1111, 4'b0000, 4'b0000, 4'b0100, "t2 rr2");
    apply_stimulus(4'b1111, 4'b0000, 4'b0000, 4'b1000, "t2 rr3");
    apply_stimulus(4'b1111, 4'b0000, 4'b0000, 4'b0001, "t2 rr4");
    apply_stimulus(4'b1111, 4'b0000, 4'b0000, 4'b0010, "t2 rr5");
    apply_stimulus(4'b1111, 4'b0000, 4'b0000, 4'b0100, "t2 rr6");
    apply_stimulus(4'b1111, 4'b0000, 4'b0000, 4'b1000, "t2 rr7");
    apply_stimulus(4'b1111, 4'b0000, 4'b0000, 4'b0001, "t2 rr8");

    // Requester 2 locks; the lock outlives req_lock by one grant, then rotation resumes at 3.
    apply_stimulus(4'b1111, 4'b0100, 4'b0000, 4'b0010, "t3 pre");
    apply_stimulus(4'b1111, 4'b0100, 4'b0000, 4'b0100, "t3 lock1");
    apply_stimulus(4'b1111, 4'b0100, 4'b0000, 4'b0100, "t3 lock2");
    apply_stimulus(4'b1111, 4'b0000, 4'b0000, 4'b0100, "t3 lock3");
    apply_stimulus(4'b1111, 4'b0000, 4'b0000, 4'b1000, "t3 after");
    apply_stimulus(4'b0010, 4'b0010, 4'b0000, 4'b0010, "t3 lock r1");
    apply_stimulus(4'b1101, 4'b0000, 4'b0000, 4'b0100, "t3 drop r1");

    // Write by requester 1 followed immediately by a read of the same row by requester 3.
    a[1] = 9'h010;
    d[1] = 96'hF0F0_1234_1111_2222_3333_005A;
    a[3] = 9'h010;
    apply_stimulus(4'b0010, 4'b0000, 4'b0010, 4'b0010, "t4 write");
    apply_stimulus(4'b1000, 4'b0000, 4'b0000, 4'b1000, "t4 read");
    apply_stimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, "t4 idle");
    check_output("t4 idle pim_addr hold", 96'(pim_addr1), 96'h010);
    repeat (4) apply_stimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, "t4 drain");

    // Read in flight, then asynchronous reset drops it.
    apply_stimulus(4'b0001, 4'b0000, 4'b0000, 4'b0001, "t5 read");
    reset = 1'b0;
    req = 4'b0000;
    q1.delete();
    q3.delete();
    #1;
    check_output("t5 rst pim_we", 96'(pim_we1), 96'd0);
    check_output("t5 rst pim_addr", 96'(pim_addr1), 96'd0);
    check_output("t5 rst busy lat1", 96'(busy1), 96'd0);
    check_output("t5 rst busy lat3", 96'(busy3), 96'd0);
    check_output("t5 rst rsp_valid", 96'(rsp_valid1), 96'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (6) apply_stimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, "t5 quiet");

    // Pointer restarts at 0; four back-to-back reads.
    apply_stimulus(4'b1111, 4'b0000, 4'b0000, 4'b0001, "t6 b2b0");
    apply_stimulus(4'b1111, 4'b0000, 4'b0000, 4'b0010, "t6 b2b1");
    apply_stimulus(4'b1111, 4'b0000, 4'b0000, 4'b0100, "t6 b2b2");
    apply_stimulus(4'b1111, 4'b0000, 4'b0000, 4'b1000, "t6 b2b3");
    req = 4'b0000;

    for (int n = 0; n < 20 && (q1.size() != 0 || q3.size() != 0); n++) @(posedge clk);
    @(negedge clk);
    #1;
    check_output("drain q lat1", 96'(q1.size()), 96'd0);
    check_output("drain q lat3", 96'(q3.size()), 96'd0);
    check_output("final busy", 96'(busy3), 96'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
